// File: rtl/sb_alloc_ctrl_pkg.sv
// Core configuration and the scoreboard allocation types derived from it.
// Shared by the allocation controller and anything that carries entry IDs.
package sb_alloc_ctrl_pkg;

  localparam int unsigned CfgNrScoreboardEntries = 8;
  localparam int unsigned CfgNrCommitPorts       = 2;

  localparam int unsigned NR_SB_ENTRIES   = CfgNrScoreboardEntries;
  localparam int unsigned NR_COMMIT_PORTS = CfgNrCommitPorts;
  localparam int unsigned SB_IDW          = $clog2(NR_SB_ENTRIES);

  typedef logic [SB_IDW-1:0] sb_id_t;

endpackage

// File: rtl/sb_alloc_ctrl.sv
// In-order scoreboard entry allocator: hands out IDs, tracks writeback, and
// exposes the oldest contiguous run of completed entries on the commit ports.
module sb_alloc_ctrl
  import sb_alloc_ctrl_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = NR_SB_ENTRIES,
  parameter int unsigned NR_COMMIT_PORTS = sb_alloc_ctrl_pkg::NR_COMMIT_PORTS,
  localparam int unsigned IDW            = $clog2(NR_ENTRIES)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           alloc_valid_i,
  output logic                           alloc_ready_o,
  output logic [IDW-1:0]                 alloc_id_o,
  input  logic                           wb_valid_i,
  input  logic [IDW-1:0]                 wb_id_i,
  output logic [NR_COMMIT_PORTS-1:0]     commit_valid_o,
  output logic [NR_COMMIT_PORTS*IDW-1:0] commit_id_o,
  input  logic [NR_COMMIT_PORTS-1:0]     commit_ack_i,
  output logic [IDW:0]                   count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned CW = IDW + 1;

  logic [IDW-1:0]        issue_ptr_q, issue_ptr_d;
  logic [IDW-1:0]        commit_ptr_q, commit_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [NR_ENTRIES-1:0] done_q, done_d;

  logic [IDW-1:0]             commit_id [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] entry_rdy;
  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [NR_COMMIT_PORTS-1:0] retire;
  logic [CW-1:0]              retire_n;
  logic                       alloc_fire;

  assign full_o        = (count_q == CW'(NR_ENTRIES));
  assign empty_o       = (count_q == '0);
  assign count_o       = count_q;
  assign alloc_ready_o = ~full_o;
  assign alloc_id_o    = issue_ptr_q;
  assign alloc_fire    = alloc_valid_i & alloc_ready_o;

  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_commit
    assign commit_id[k]                = commit_ptr_q + IDW'(k);
    assign entry_rdy[k]                = valid_q[commit_id[k]] & done_q[commit_id[k]];
    assign commit_id_o[k*IDW +: IDW]   = commit_id[k];
  end

  // Both the visible window and the retired set stop at the first hole, so
  // commits stay in order and an ack beyond a gap has no effect.
  always_comb begin
    commit_valid = '0;
    retire       = '0;
    retire_n     = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (k == 0) begin
        commit_valid[k] = entry_rdy[k];
        retire[k]       = entry_rdy[k] & commit_ack_i[k];
      end else begin
        commit_valid[k] = entry_rdy[k] & commit_valid[k-1];
        retire[k]       = commit_valid[k] & commit_ack_i[k] & retire[k-1];
      end
      retire_n = retire_n + CW'(retire[k]);
    end
  end

  assign commit_valid_o = commit_valid;

  // Retirement clears last, so a writeback racing a retire on the same entry
  // cannot leave a stale done bit behind.
  always_comb begin
    valid_d      = valid_q;
    done_d       = done_q;
    issue_ptr_d  = issue_ptr_q + IDW'(alloc_fire);
    commit_ptr_d = commit_ptr_q + retire_n[IDW-1:0];
    count_d      = count_q + CW'(alloc_fire) - retire_n;
    if (alloc_fire) begin
      valid_d[issue_ptr_q] = 1'b1;
      done_d[issue_ptr_q]  = 1'b0;
    end
    if (wb_valid_i && valid_q[wb_id_i]) begin
      done_d[wb_id_i] = 1'b1;
    end
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (retire[k]) begin
        valid_d[commit_id[k]] = 1'b0;
        done_d[commit_id[k]]  = 1'b0;
      end
    end
    if (flush_i) begin
      valid_d      = '0;
      done_d       = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      done_q       <= '0;
    end else begin
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_sb_alloc_ctrl.sv
// Directed bench for the scoreboard allocator: fill/full, in-order commit,
// ack gaps, stray writeback, flush and asynchronous reset.
module tb_sb_alloc_ctrl;
  import sb_alloc_ctrl_pkg::*;

  logic         clk;
  logic         rstN;
  logic         flush;
  logic         allocValid;
  logic         allocReady;
  sb_id_t       allocId;
  logic         wbValid;
  sb_id_t       wbId;
  logic [1:0]   commitValid;
  logic [5:0]   commitId;
  logic [1:0]   commitAck;
  logic [3:0]   count;
  logic         full;
  logic         empty;

  int compared   = 0;
  int mismatched = 0;

  sb_alloc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .flush_i        (flush),
    .alloc_valid_i  (allocValid),
    .alloc_ready_o  (allocReady),
    .alloc_id_o     (allocId),
    .wb_valid_i     (wbValid),
    .wb_id_i        (wbId),
    .commit_valid_o (commitValid),
    .commit_id_o    (commitId),
    .commit_ack_i   (commitAck),
    .count_o        (count),
    .full_o         (full),
    .empty_o        (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic a, input logic wv, input int wid,
                               input logic [1:0] ack, input logic fl);
    allocValid = a;
    wbValid    = wv;
    wbId       = sb_id_t'(wid);
    commitAck  = ack;
    flush      = fl;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0);
    #1;
    checkOutput("rst_ready", 32'(allocReady), 1);
    checkOutput("rst_id", 32'(allocId), 0);
    checkOutput("rst_cv", 32'(commitValid), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_cid", 32'(commitId), 8);
    #10 rstN = 1'b1;
    tick();

    $display("[TB] fill to full");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 0, 2'b00, 0);
      checkOutput("fill_id", 32'(allocId), i);
      checkOutput("fill_count", 32'(count), i);
      checkOutput("fill_ready", 32'(allocReady), 1);
      tick();
    end
    applyStimulus(1, 0, 0, 2'b00, 0);
    checkOutput("full_count", 32'(count), 8);
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("full_ready", 32'(allocReady), 0);
    tick();
    checkOutput("ninth_not_granted", 32'(count), 8);

    $display("[TB] out-of-order writeback, in-order commit");
    applyStimulus(0, 1, 1, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("wb1_cv", 32'(commitValid), 0);
    applyStimulus(0, 1, 0, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("wb0_cv", 32'(commitValid), 3);
    checkOutput("wb0_cid", 32'(commitId), 8);

    $display("[TB] retire while full with alloc pending");
    applyStimulus(1, 0, 0, 2'b11, 0);
    checkOutput("fullack_ready", 32'(allocReady), 0);
    tick();
    applyStimulus(1, 0, 0, 2'b00, 0);
    checkOutput("after_ack_count", 32'(count), 6);
    checkOutput("after_ack_ready", 32'(allocReady), 1);
    checkOutput("wrap_id", 32'(allocId), 0);
    checkOutput("after_ack_cid", 32'(commitId), 26);
    checkOutput("after_ack_cv", 32'(commitValid), 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("wrap_count", 32'(count), 7);
    checkOutput("wrap_next_id", 32'(allocId), 1);

    $display("[TB] ack gap");
    applyStimulus(0, 1, 2, 2'b00, 0);
    tick();
    applyStimulus(0, 1, 3, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b10, 0);
    checkOutput("gap_cv_before", 32'(commitValid), 3);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("gap_count", 32'(count), 7);
    checkOutput("gap_cv", 32'(commitValid), 3);
    checkOutput("gap_cid", 32'(commitId), 26);
    applyStimulus(0, 0, 0, 2'b01, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("one_count", 32'(count), 6);
    checkOutput("one_cv", 32'(commitValid), 1);
    checkOutput("one_cid", 32'(commitId), 35);

    $display("[TB] flush dominates");
    applyStimulus(0, 0, 0, 2'b01, 0);
    tick();
    applyStimulus(0, 1, 4, 2'b00, 0);
    tick();
    applyStimulus(0, 1, 5, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("preflush_count", 32'(count), 5);
    checkOutput("preflush_cv", 32'(commitValid), 3);
    applyStimulus(1, 1, 6, 2'b11, 1);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("flush_count", 32'(count), 0);
    checkOutput("flush_empty", 32'(empty), 1);
    checkOutput("flush_id", 32'(allocId), 0);
    checkOutput("flush_cv", 32'(commitValid), 0);
    checkOutput("flush_ready", 32'(allocReady), 1);
    checkOutput("flush_cid", 32'(commitId), 8);

    $display("[TB] writeback to unallocated entry");
    applyStimulus(1, 0, 0, 2'b00, 0);
    tick();
    tick();
    applyStimulus(0, 1, 5, 2'b00, 0);
    tick();
    applyStimulus(1, 0, 0, 2'b00, 0);
    checkOutput("stray_count", 32'(count), 2);
    tick();
    tick();
    tick();
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("refill_count", 32'(count), 6);
    checkOutput("refill_id", 32'(allocId), 6);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, i, 2'b00, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 2'b11, 0);
    checkOutput("drain_cv", 32'(commitValid), 3);
    tick();
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("drain_count", 32'(count), 2);
    checkOutput("stray_cv", 32'(commitValid), 1);
    checkOutput("stray_cid", 32'(commitId), 44);
    applyStimulus(0, 1, 5, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b01, 0);
    checkOutput("wb5_cv", 32'(commitValid), 3);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("last_cv", 32'(commitValid), 1);
    checkOutput("last_cid", 32'(commitId), 53);
    checkOutput("last_count", 32'(count), 1);

    $display("[TB] asynchronous reset");
    applyStimulus(1, 0, 0, 2'b00, 0);
    tick();
    applyStimulus(0, 0, 0, 2'b00, 0);
    checkOutput("prereset_count", 32'(count), 2);
    rstN = 1'b0;
    #1;
    checkOutput("async_count", 32'(count), 0);
    checkOutput("async_empty", 32'(empty), 1);
    checkOutput("async_id", 32'(allocId), 0);
    checkOutput("async_cv", 32'(commitValid), 0);
    #1 rstN = 1'b1;
    tick();
    checkOutput("post_reset_count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
